// File: rtl/clk_divider_prog.sv
// Multi-channel programmable clock divider with glitch-free ratio updates,
// glitch-free enable/disable and a per-channel tick strobe.
module clk_divider_prog #(
    parameter int N_CH  = 4,
    parameter int DIV_W = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic [N_CH-1:0]         i_en,
    input  logic [N_CH*DIV_W-1:0]   i_div,
    output logic [N_CH-1:0]         o_clk,
    output logic [N_CH-1:0]         o_tick,
    output logic [N_CH-1:0]         o_active
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        state_t           state;
        logic [DIV_W-1:0] d_in;
        logic [DIV_W-1:0] d_eff;
        logic [DIV_W-1:0] shadow;
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] cnt_nxt;
        logic [DIV_W-1:0] half;
        logic             start;
        logic             last;
        logic             clk_q;
        logic             tick_q;
        logic             active_q;

        assign d_in    = i_div[c*DIV_W +: DIV_W];
        // A ratio of 1 cannot produce a clock; run it as the fastest legal one.
        assign d_eff   = (d_in == DIV_W'(1)) ? DIV_W'(2) : d_in;
        assign start   = i_en[c] && (d_in != '0);
        assign last    = (cnt == shadow - DIV_W'(1));
        assign cnt_nxt = cnt + DIV_W'(1);
        assign half    = shadow >> 1;

        // Outputs are computed for the next count so they come straight from flops.
        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                state    <= IDLE;
                shadow   <= '0;
                cnt      <= '0;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
                active_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt    <= '0;
                        clk_q  <= 1'b0;
                        tick_q <= 1'b0;
                        if (start) begin
                            state    <= RUN;
                            shadow   <= d_eff;
                            active_q <= 1'b1;
                        end else begin
                            active_q <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (last) begin
                            cnt    <= '0;
                            clk_q  <= 1'b0;
                            tick_q <= 1'b0;
                            if (start) begin
                                shadow <= d_eff;
                            end else begin
                                state    <= IDLE;
                                active_q <= 1'b0;
                            end
                        end else begin
                            cnt    <= cnt_nxt;
                            clk_q  <= (cnt_nxt >= half);
                            tick_q <= (cnt_nxt == half);
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        cnt      <= '0;
                        clk_q    <= 1'b0;
                        tick_q   <= 1'b0;
                        active_q <= 1'b0;
                    end
                endcase
            end
        end

        assign o_clk[c]    = clk_q;
        assign o_tick[c]   = tick_q;
        assign o_active[c] = active_q;
    end

endmodule

// File: tb/tb_clk_divider_prog.sv
// Scoreboard bench for clk_divider_prog: per-channel expected
// {clk,tick,active} queues filled with stimulus, drained each cycle.
module tb_clk_divider_prog;

    localparam int N_CH  = 4;
    localparam int DIV_W = 16;

    logic                  i_clk = 1'b0;
    logic                  i_reset_n;
    logic [N_CH-1:0]       i_en;
    logic [N_CH*DIV_W-1:0] i_div;
    logic [N_CH-1:0]       o_clk;
    logic [N_CH-1:0]       o_tick;
    logic [N_CH-1:0]       o_active;

    int n_chk  = 0;
    int n_fail = 0;

    logic [2:0] sb [N_CH][$];

    always #5 i_clk = ~i_clk;

    clk_divider_prog #(
        .N_CH  (N_CH),
        .DIV_W (DIV_W)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_en      (i_en),
        .i_div     (i_div),
        .o_clk     (o_clk),
        .o_tick    (o_tick),
        .o_active  (o_active)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {clk,tick,active} for cycle k of a period of length de.
    function automatic logic [2:0] exp_at(input int k, input int de);
        logic hi;
        logic tk;
        hi = (k >= de / 2);
        tk = (k == de / 2);
        return {hi, tk, 1'b1};
    endfunction

    task automatic push_part(input int c, input int de, input int n);
        for (int k = 0; k < n; k++) sb[c].push_back(exp_at(k, de));
    endtask

    task automatic push_period(input int c, input int de);
        push_part(c, de, de);
    endtask

    task automatic push_idle(input int c, input int n);
        for (int k = 0; k < n; k++) sb[c].push_back(3'b000);
    endtask

    task automatic set_div(input int c, input int d);
        i_div[c*DIV_W +: DIV_W] = DIV_W'(d);
    endtask

    task automatic step(input int n);
        logic [2:0] e;
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk);
            #1;
            for (int c = 0; c < N_CH; c++) begin
                if (sb[c].size() != 0) begin
                    e = sb[c].pop_front();
                    check($sformatf("ch%0d", c),
                          {29'd0, o_clk[c], o_tick[c], o_active[c]}, {29'd0, e});
                end
            end
        end
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_en      = '0;
        i_div     = '0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_clk", o_clk, 0);
        check("rst_tick", o_tick, 0);
        check("rst_active", o_active, 0);
        i_reset_n = 1'b1;

        // All channels running, then async reset in the high phase.
        i_en = '1;
        for (int c = 0; c < N_CH; c++) begin
            set_div(c, 3);
            push_period(c, 3);
            push_period(c, 3);
            push_part(c, 3, 2);
        end
        step(8);
        check("pre_rst_clk", o_clk, 4'hf);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("async_rst_clk", o_clk, 0);
        check("async_rst_tick", o_tick, 0);
        check("async_rst_active", o_active, 0);
        i_en = '0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        for (int c = 0; c < N_CH; c++) push_idle(c, 4);
        step(4);

        // Even and odd ratios concurrently.
        set_div(0, 4);
        set_div(1, 5);
        i_en = 4'b0011;
        for (int p = 0; p < 5; p++) push_period(0, 4);
        for (int p = 0; p < 4; p++) push_period(1, 5);
        push_idle(2, 20);
        push_idle(3, 20);
        step(20);

        // Ratio change mid-period on ch0; ch1 stops at its boundary.
        i_en[1] = 1'b0;
        push_idle(1, 16);
        push_period(0, 4);
        push_period(0, 6);
        push_period(0, 6);
        step(2);
        set_div(0, 6);
        step(14);

        // Disable in the high phase of a D=8 period.
        set_div(0, 8);
        push_period(0, 8);
        push_idle(0, 4);
        step(6);
        i_en[0] = 1'b0;
        step(6);

        // D=1 clamps to 2; D=0 holds idle, then D=3 starts at once.
        set_div(2, 1);
        set_div(3, 0);
        i_en = 4'b1100;
        for (int p = 0; p < 3; p++) push_period(2, 2);
        push_idle(3, 6);
        push_idle(0, 6);
        step(6);
        set_div(3, 3);
        for (int p = 0; p < 3; p++) push_period(2, 2);
        push_period(3, 3);
        push_period(3, 3);
        step(6);
        i_en = '0;
        push_idle(2, 2);
        push_idle(3, 2);
        step(2);

        // Maximum ratio.
        set_div(0, 65535);
        i_en[0] = 1'b1;
        push_period(0, 65535);
        step(65535);
        i_en[0] = 1'b0;
        push_idle(0, 2);
        step(2);

        // Async reset at cnt=4 of a D=6 period, then a fresh start.
        set_div(1, 6);
        i_en[1] = 1'b1;
        push_part(1, 6, 5);
        step(5);
        check("mid_high_clk", o_clk[1], 1);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("rst_mid_clk", o_clk[1], 0);
        check("rst_mid_active", o_active[1], 0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        push_period(1, 6);
        push_period(1, 6);
        step(12);
        i_en = '0;
        push_idle(1, 2);
        step(2);

        for (int c = 0; c < N_CH; c++) check("sb_empty", sb[c].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_divider_prog.md
Name: clk_divider_prog

Overview:
- Multi-channel programmable clock divider; successor to the fixed single-ratio divider.
- Generates N_CH independent divided clocks from one system clock.
- Each channel has:
  - a runtime divide ratio
  - period-boundary (glitch-free) ratio updates
  - glitch-free enable/disable
  - a one-cycle tick strobe, so downstream logic can use clock enables instead of derived clocks.

Parameters:
- N_CH, 4, number of independent divider channels (>=1).
- DIV_W, 16, width of each channel's divide-ratio field; max ratio 2^DIV_W-1.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_en  input  N_CH  per-channel run enable; bit c controls channel c.
- i_div  input  N_CH*DIV_W  per-channel divide ratio D; channel c uses bits [c*DIV_W +: DIV_W]; D = output period in i_clk cycles.
- o_clk  output  N_CH  divided clock per channel, registered.
- o_tick  output  N_CH  one-cycle pulse, high in the first i_clk cycle of each o_clk high phase.
- o_active  output  N_CH  channel is running a period (not idle).

Behaviour:
- Reset: i_reset_n low immediately (no clock needed) forces all o_clk=0, o_tick=0, o_active=0, counters=0, shadow ratios=0, all channels IDLE. Reset mid-period truncates the output; no completion.
- Per-channel FSM, two states: IDLE, RUN. Channels fully independent; no shared state.
- Ratio clamp: effective ratio De = 2 if sampled D==1, else D. D==0 means "do not run".
- IDLE:
  - o_clk=0, o_active=0, counter=0.
  - On a rising edge with i_en[c]=1 and D!=0: latch De into shadow, counter=0, go RUN (o_active=1 from that edge).
  - i_en=1 with D==0: remain IDLE, re-evaluate every cycle.
- RUN:
  - Counter cnt counts 0..De-1, one per cycle, DIV_W bits wide. L = De>>1.
  - o_clk=0 while cnt<L; o_clk=1 while cnt>=L. Low phase floor(De/2) cycles, high phase ceil(De/2) cycles.
  - Even ratios give 50% duty; odd ratios are high-biased by one cycle.
  - o_tick=1 exactly in the cycle cnt==L (first high cycle), else 0.
- Period boundary (cycle with cnt==De-1), evaluated on the next edge:
  - i_en[c]=1 and current D!=0: latch new De, cnt=0, stay RUN. The new ratio applies from the next period; no partial periods.
  - Otherwise: go IDLE, o_clk=0, o_active=0.
- Mid-period changes:
  - Changes to i_div mid-period are ignored; only the value present at the boundary edge is used.
  - Deassertion of i_en mid-period is ignored until the boundary; the current high phase always completes. No runt pulses.
- Wrap: cnt never exceeds De-1. Max ratio 2^DIV_W-1 gives low (2^DIV_W-1)>>1 cycles, high one more.
- Latency: i_en rising sampled at edge E0 → o_active=1 after E0. First o_clk rise occurs L cycles after E0, with o_tick in that same cycle.
- o_clk, o_tick and o_active are all driven directly from flops; no combinational path from inputs to outputs.

Test Plan:
- Reset and start-up: assert i_reset_n=0 with all channels running, no clock edges → all outputs 0 asynchronously. Release; i_en=0 → outputs stay 0.
- Even and odd ratios:
  - ch0 D=4, i_en=1 → o_clk pattern 0,0,1,1 repeating; o_tick every 4 cycles, aligned to the rise.
  - ch1 D=5 → low 2, high 3.
  - Both run concurrently and independently.
- Ratio change: ch0 running D=4, change i_div to 6 at cnt=1 → current period completes as 0,0,1,1; next periods 0,0,0,1,1,1.
- Glitch-free disable: D=8, drop i_en during cnt=5 → o_clk stays high through cnt=7, then 0; o_active falls at the boundary; no further ticks.
- Boundary values:
  - D=1 → clamped to 2; o_clk toggles every cycle with a tick every 2 cycles.
  - D=0 with i_en=1 → stays IDLE.
  - D=0→3 while enabled → starts within one cycle.
  - D=65535 (DIV_W=16) → low 32767, high 32768.
- Async reset mid-high phase: D=6, assert i_reset_n=0 at cnt=4 between edges → o_clk and o_active drop immediately. After release with i_en=1 → fresh period starting at cnt=0.
